fir_out_requant: RTL and testbench

//  Downstream of fir_second decimator: consumes 34-bit Avalon-ST samples, rounds
//  (round-half-up) and right-shifts by SHIFT, saturates to 16 bits, buffers in a FIFO,
//  and presents a ready/valid stream to the next consumer (DAC/UART packer).

---
 rtl/fir_out_requant_pkg.sv | 16 +
 rtl/fir_out_requant_if.sv | 29 ++
 rtl/fir_out_requant_sync_fifo_fwft.sv | 63 ++++++
 rtl/fir_out_requant.sv | 136 +++++++++++++
 tb/tb_fir_out_requant.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_out_requant_pkg.sv
// fir_out_requant_pkg: shared defaults for the FIR output requantiser.
//   DEF_IN_W / DEF_OUT_W : default input / output sample widths
//   SAT_MAX / SAT_MIN    : clip limits for the default output width
//   lvl_w()              : width of a FIFO occupancy count (0..depth inclusive)
package fir_out_requant_pkg;
  localparam int DEF_IN_W  = 34;
  localparam int DEF_OUT_W = 16;

  localparam logic signed [DEF_OUT_W-1:0] SAT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
  localparam logic signed [DEF_OUT_W-1:0] SAT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

  // Occupancy must represent DEPTH itself, hence the extra bit.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fir_out_requant_if.sv
// fir_out_requant_if: Avalon-ST sink (from fir_second) and ready/valid source
// (to the DAC/UART packer) bundled together.
//   ast_sink_*   : upstream sample, no backpressure
//   ast_source_* : FIFO head, popped on valid & ready
//   master : the side that produces sink samples and consumes the source stream
//   slave  : the requantiser
interface fir_out_requant_if
  import fir_out_requant_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) ();
  logic signed [IN_W-1:0]  ast_sink_data;
  logic                    ast_sink_valid;
  logic [1:0]              ast_sink_error;
  logic signed [OUT_W-1:0] ast_source_data;
  logic                    ast_source_valid;
  logic                    ast_source_ready;

  modport master (
    output ast_sink_data, ast_sink_valid, ast_sink_error, ast_source_ready,
    input  ast_source_data, ast_source_valid
  );

  modport slave (
    input  ast_sink_data, ast_sink_valid, ast_sink_error, ast_source_ready,
    output ast_source_data, ast_source_valid
  );
endinterface

// File: rtl/fir_out_requant_sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   wr_en/wr_data : push; ignored when full unless a pop happens the same cycle
//   rd_en      : pop the head; ignored when empty
//   rd_data    : current head (0 while empty)
//   full/empty/level : status, level in 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_fwft
  import fir_out_requant_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_d, wp_q, rp_d, rp_q;
  logic [LW-1:0]     cnt_d, cnt_q;
  logic              do_wr, do_rd;

  always_comb begin
    do_rd = rd_en && (cnt_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    do_wr = wr_en && ((cnt_q != FULL_CNT) || do_rd);
    wp_d  = wp_q + AW'(do_wr);
    rp_d  = rp_q + AW'(do_rd);
    cnt_d = cnt_q + LW'(do_wr) - LW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset; the count gates the head so stale words never show.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= wr_data;
  end

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign level   = cnt_q;
  assign rd_data = empty ? '0 : mem_q[rp_q];
endmodule

// File: rtl/fir_out_requant.sv
// fir_out_requant: round-half-up, arithmetic shift by SHIFT, saturate to OUT_W
// bits, buffer in a FWFT FIFO and present a ready/valid stream.
//   clk, reset : 130 MHz DSP clock, synchronous active-high reset
//   io         : sink (34-bit sample, valid, error) + source (data, valid, ready)
//   clr_flags  : pulse clears overflow / err_seen (and sat_count when present)
//   fifo_level : FIFO occupancy 0..FIFO_DEPTH
//   overflow   : sticky, a sample was dropped on a full FIFO
//   err_seen   : sticky, a sample arrived with nonzero error
//   sat_count  : saturated samples, only when FIR_OUT_SAT_CNT_EN is defined
// Pipeline: stage1 round/shift, stage2 saturate, stage3 FIFO write port.
// A sample captured at edge N shows on ast_source_valid after edge N+3.
module fir_out_requant
  import fir_out_requant_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int SHIFT      = 7,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  fir_out_requant_if.slave              io,
  input  logic                          clr_flags,
  output logic [lvl_w(FIFO_DEPTH)-1:0]  fifo_level,
  output logic                          overflow,
  output logic                          err_seen
`ifdef FIR_OUT_SAT_CNT_EN
  ,
  output logic [15:0]                   sat_count
`endif
);
  localparam int STAGES = 2;
  // One guard bit so the rounding add cannot wrap at the positive extreme.
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] SMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                    accept;
  logic [STAGES:0]         vld_pipe_d, vld_pipe_q;
  logic signed [RW-1:0]    r_d, r_q;
  logic signed [OUT_W-1:0] sat_d, sat_q;
  logic signed [OUT_W-1:0] wr_data_d, wr_data_q;
  logic                    overflow_d, overflow_q;
  logic                    err_seen_d, err_seen_q;
  logic                    drop;
  logic                    fifo_full, fifo_empty;
  logic [OUT_W-1:0]        fifo_rd_data;

  always_comb begin
    // Errored samples never enter the pipeline.
    accept     = io.ast_sink_valid && (io.ast_sink_error == 2'b00);
    // vld_pipe_q[0..2] qualify stage1, stage2 and the FIFO write port.
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], accept};
    r_d        = ($signed({io.ast_sink_data[IN_W-1], io.ast_sink_data}) + RND) >>> SHIFT;

    if (r_q > SMAX)      sat_d = SMAX[OUT_W-1:0];
    else if (r_q < SMIN) sat_d = SMIN[OUT_W-1:0];
    else                 sat_d = r_q[OUT_W-1:0];

    wr_data_d  = sat_q;

    // Full with a pop the same cycle is a legal write, so only !ready drops.
    drop       = vld_pipe_q[STAGES] && fifo_full && !io.ast_source_ready;
    // Setting term is OR'd last so a new event beats a simultaneous clear.
    overflow_d = (overflow_q && !clr_flags) || drop;
    err_seen_d = (err_seen_q && !clr_flags) ||
                 (io.ast_sink_valid && (io.ast_sink_error != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      r_q        <= '0;
      sat_q      <= '0;
      wr_data_q  <= '0;
      overflow_q <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      r_q        <= r_d;
      sat_q      <= sat_d;
      wr_data_q  <= wr_data_d;
      overflow_q <= overflow_d;
      err_seen_q <= err_seen_d;
    end
  end

`ifdef FIR_OUT_SAT_CNT_EN
  logic        sat_evt_d, sat2_q, sat3_q;
  logic [15:0] sat_cnt_d, sat_cnt_q;

  always_comb begin
    sat_evt_d = (r_q > SMAX) || (r_q < SMIN);
    sat_cnt_d = clr_flags ? 16'd0 : sat_cnt_q;
    // Counts saturated samples reaching the write port, whether stored or dropped.
    if (vld_pipe_q[STAGES] && sat3_q && (sat_cnt_d != 16'hFFFF))
      sat_cnt_d = sat_cnt_d + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat2_q    <= 1'b0;
      sat3_q    <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      sat2_q    <= sat_evt_d;
      sat3_q    <= sat2_q;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_count = sat_cnt_q;
`endif

  sync_fifo_fwft #(
    .DATA_W (OUT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (vld_pipe_q[STAGES]),
    .wr_data (wr_data_q),
    .rd_en   (io.ast_source_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign io.ast_source_data  = fifo_rd_data;
  assign io.ast_source_valid = !fifo_empty;
  assign overflow            = overflow_q;
  assign err_seen            = err_seen_q;
endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: directed tests for fir_out_requant (SHIFT=7, DEPTH=16).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Build with FIR_OUT_SAT_CNT_EN defined to also exercise sat_count.
module tb_fir_out_requant;
  logic       clk = 1'b0;
  logic       reset;
  logic       clr_flags;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       err_seen;
`ifdef FIR_OUT_SAT_CNT_EN
  logic [15:0] sat_count;
`endif
  int checks = 0;
  int errors = 0;

  fir_out_requant_if #(.IN_W(34), .OUT_W(16)) bus ();

  fir_out_requant #(
    .IN_W(34), .OUT_W(16), .SHIFT(7), .FIFO_DEPTH(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .io         (bus),
    .clr_flags  (clr_flags),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .err_seen   (err_seen)
`ifdef FIR_OUT_SAT_CNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle sample on the sink; returns 1 unit after the capturing edge.
  task automatic push(input int d, input logic [1:0] e);
    bus.ast_sink_data  = 34'(d);
    bus.ast_sink_valid = 1'b1;
    bus.ast_sink_error = e;
    tick();
    bus.ast_sink_valid = 1'b0;
    bus.ast_sink_error = 2'b00;
  endtask

  // Push one sample with ready=1 and capture the head when valid first rises.
  task automatic run_one(input int d, output logic signed [15:0] got, output bit seen);
    seen = 1'b0;
    got  = 'x;
    push(d, 2'b00);
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.ast_source_valid === 1'b1) begin
        seen = 1'b1;
        got  = bus.ast_source_data;
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (bus.ast_source_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.ast_source_valid); end
    checks++; if (bus.ast_source_data !== 16'sd0) begin errors++; $display("FAIL rst_data got %0d want 0", bus.ast_source_data); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
    checks++; if ({overflow, err_seen} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {overflow, err_seen}); end
`ifdef FIR_OUT_SAT_CNT_EN
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL rst_satcnt got %0d want 0", sat_count); end
`endif
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    push(192, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.ast_source_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid cycle %0d got %b want 0", i, bus.ast_source_valid); end
    end
    @(negedge clk);
    checks++; if (bus.ast_source_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b want 1", bus.ast_source_valid); end
    checks++; if (bus.ast_source_data !== 16'sd2) begin errors++; $display("FAIL lat_data got %0d want 2", bus.ast_source_data); end
    tick();
    @(negedge clk);
    checks++; if (bus.ast_source_valid !== 1'b0) begin errors++; $display("FAIL lat_drain_valid got %b want 0", bus.ast_source_valid); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL lat_drain_level got %0d want 0", fifo_level); end
    tick();
  endtask

  task automatic test_rounding();
    int din [4] = '{-192, -64, 63, 64};
    int dexp[4] = '{-1, 0, 0, 1};
    logic signed [15:0] got;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      run_one(din[i], got, seen);
      checks++; if (!seen || got !== 16'(dexp[i])) begin errors++; $display("FAIL round in=%0d seen=%b got %0d want %0d", din[i], seen, got, dexp[i]); end
    end
  endtask

  // Edges of the clip range: 4194176/-4194304 map exactly to the limits,
  // 4194240 rounds up past +32767, -4194369 floors below -32768.
  task automatic test_saturation();
    int din [6] = '{5000000, -5000000, 4194176, 4194240, -4194304, -4194369};
    int dexp[6] = '{32767, -32768, 32767, 32767, -32768, -32768};
    logic signed [15:0] got;
    bit seen;
    for (int i = 0; i < 6; i++) begin
      run_one(din[i], got, seen);
      checks++; if (!seen || got !== 16'(dexp[i])) begin errors++; $display("FAIL sat in=%0d seen=%b got %0d want %0d", din[i], seen, got, dexp[i]); end
    end
`ifdef FIR_OUT_SAT_CNT_EN
    checks++; if (sat_count !== 16'd4) begin errors++; $display("FAIL sat_count got %0d want 4", sat_count); end
`endif
  endtask

  task automatic test_back_to_back();
    int dexp[3] = '{-2, -1, 3};
    bus.ast_source_ready = 1'b1;
    push(-256, 2'b00);
    push(-128, 2'b00);
    push(384, 2'b00);
    @(negedge clk);
    checks++; if (bus.ast_source_valid !== 1'b0) begin errors++; $display("FAIL b2b_early got %b want 0", bus.ast_source_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.ast_source_valid !== 1'b1 || bus.ast_source_data !== 16'(dexp[i])) begin errors++; $display("FAIL b2b_data idx %0d got v=%b d=%0d want v=1 d=%0d", i, bus.ast_source_valid, bus.ast_source_data, dexp[i]); end
    end
    @(negedge clk);
    checks++; if (bus.ast_source_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", bus.ast_source_valid); end
    tick();
  endtask

  task automatic test_overflow();
    bus.ast_source_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b want 0", overflow); end
    for (int k = 1; k <= 17; k++) push(k * 128, 2'b00);
    repeat (4) tick();
    @(negedge clk);
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (bus.ast_source_valid !== 1'b1 || bus.ast_source_data !== 16'sd1) begin errors++; $display("FAIL ovf_head got v=%b d=%0d want v=1 d=1", bus.ast_source_valid, bus.ast_source_data); end
    tick();
    @(negedge clk);
    checks++; if (bus.ast_source_data !== 16'sd1) begin errors++; $display("FAIL ovf_stable got %0d want 1", bus.ast_source_data); end
    tick();
    bus.ast_source_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++; if (bus.ast_source_valid !== 1'b1 || bus.ast_source_data !== 16'(k)) begin errors++; $display("FAIL ovf_read idx %0d got v=%b d=%0d want v=1 d=%0d", k, bus.ast_source_valid, bus.ast_source_data, k); end
    end
    @(negedge clk);
    checks++; if (bus.ast_source_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL ovf_empty got v=%b lvl=%0d want v=0 lvl=0", bus.ast_source_valid, fifo_level); end
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", overflow); end
    tick();
  endtask

  // Writes land exactly on the cycles a full FIFO is popped: level holds at 16.
  task automatic test_full_rw();
    bus.ast_source_ready = 1'b0;
    for (int k = 1; k <= 16; k++) push(k * 128, 2'b00);
    repeat (4) tick();
    fork
      begin
        for (int k = 17; k <= 20; k++) push(k * 128, 2'b00);
      end
      begin
        repeat (3) tick();
        bus.ast_source_ready = 1'b1;
      end
    join
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL frw_level0 got %0d want 16", fifo_level); end
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      checks++; if (bus.ast_source_valid !== 1'b1 || bus.ast_source_data !== 16'(k)) begin errors++; $display("FAIL frw_read idx %0d got v=%b d=%0d want v=1 d=%0d", k, bus.ast_source_valid, bus.ast_source_data, k); end
      if (k == 5) begin
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL frw_level3 got %0d want 16", fifo_level); end
      end
    end
    @(negedge clk);
    checks++; if (bus.ast_source_valid !== 1'b0) begin errors++; $display("FAIL frw_empty got %b want 0", bus.ast_source_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf got %b want 0", overflow); end
    tick();
  endtask

  task automatic test_error();
    push(1280, 2'b01);
    repeat (5) tick();
    @(negedge clk);
    checks++; if (bus.ast_source_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL err_dropped got v=%b lvl=%0d want v=0 lvl=0", bus.ast_source_valid, fifo_level); end
    checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL err_seen got %b want 1", err_seen); end
    tick();
    // Clear in the same cycle as a new errored sample: the set must win.
    clr_flags = 1'b1;
    push(640, 2'b10);
    clr_flags = 1'b0;
    @(negedge clk);
    checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL err_set_wins got %b want 1", err_seen); end
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    @(negedge clk);
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", err_seen); end
`ifdef FIR_OUT_SAT_CNT_EN
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL satcnt_clr got %0d want 0", sat_count); end
`endif
    tick();
  endtask

  task automatic test_reset_midstream();
    bus.ast_source_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(k * 128, 2'b00);
    repeat (4) tick();
    checks++; if (fifo_level !== 5'd5) begin errors++; $display("FAIL rmid_pre_level got %0d want 5", fifo_level); end
    push(6 * 128, 2'b00);
    push(7 * 128, 2'b00);
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (bus.ast_source_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL rmid_flush got v=%b lvl=%0d want v=0 lvl=0", bus.ast_source_valid, fifo_level); end
    checks++; if (bus.ast_source_data !== 16'sd0) begin errors++; $display("FAIL rmid_data got %0d want 0", bus.ast_source_data); end
    tick();
    reset = 1'b0;
    bus.ast_source_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (bus.ast_source_valid !== 1'b0 || fifo_level !== 5'd0) begin errors++; $display("FAIL rmid_stale cycle %0d got v=%b lvl=%0d want v=0 lvl=0", i, bus.ast_source_valid, fifo_level); end
    end
  endtask

  initial begin
    reset                = 1'b1;
    clr_flags            = 1'b0;
    bus.ast_sink_data    = '0;
    bus.ast_sink_valid   = 1'b0;
    bus.ast_sink_error   = 2'b00;
    bus.ast_source_ready = 1'b1;
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_overflow();
    test_full_rw();
    test_error();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
